// File: rtl/busblaster_pkg.sv
// Shared definitions for the BusBlaster V3 CPLD reset logic: FSM encoding,
// default timing constants and counter sizing.
package busblaster_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RELEASE = 2'd2,
    ST_EXT     = 2'd3
  } state_e;

  localparam int DEF_DEBOUNCE_CYCLES  = 16384;
  localparam int DEF_MIN_PULSE_CYCLES = 1000;
  localparam int DEF_RELEASE_TIMEOUT  = 4096;
  localparam int DEF_BLINK_DIV        = 65536;
  localparam int DEF_TRST_WITH_SRST   = 1;

  localparam int SYNC_STAGES = 2;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronizes and debounces the active-low BUTTON, emitting a one-cycle
// press pulse when the accepted level falls.
module button_debounce
  import busblaster_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic button_i,
  output logic press_o
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   press_q, press_d;
  logic                   btn_s;

  assign btn_s = sync_q[SYNC_STAGES-1];

  // Any cycle where the synced level agrees with the stable one restarts the run.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    if (btn_s != stable_q) begin
      if (cnt_q == LAST) begin
        stable_d = btn_s;
        press_d  = ~btn_s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q   <= '1;
      cnt_q    <= '0;
      stable_q <= 1'b1;
      press_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], button_i};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      press_q  <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/srst_sequencer.sv
// nSRST / nTRST sequencer: arbitrates host and button reset requests,
// stretches the pulse to a minimum width and detects target-held resets.
module srst_sequencer
  import busblaster_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
  parameter int MIN_PULSE_CYCLES = DEF_MIN_PULSE_CYCLES,
  parameter int RELEASE_TIMEOUT  = DEF_RELEASE_TIMEOUT,
  parameter int BLINK_DIV        = DEF_BLINK_DIV,
  parameter int TRST_WITH_SRST   = DEF_TRST_WITH_SRST
) (
  input  logic CLK,
  input  logic RST,
  input  logic BUTTON,
  input  logic HOST_SRST_REQ,
  input  logic HOST_TRST_REQ,
  input  logic NSRST_IN,
  output logic NSRST_OE,
  output logic NTRST,
  output logic SRST_STATUS,
  output logic BUSY,
  output logic LED
);

  localparam int PW = cnt_w((MIN_PULSE_CYCLES > RELEASE_TIMEOUT) ? MIN_PULSE_CYCLES
                                                                 : RELEASE_TIMEOUT);
  localparam logic [PW-1:0] PULSE_LAST = PW'(MIN_PULSE_CYCLES - 1);
  localparam logic [PW-1:0] REL_LAST   = PW'(RELEASE_TIMEOUT - 1);
  localparam int BW = cnt_w(BLINK_DIV);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic TRST_EN = (TRST_WITH_SRST != 0);

  logic [SYNC_STAGES-1:0] srst_req_q, trst_req_q, nsrst_in_q;
  logic   srst_req_s, trst_req_s, nsrst_s, press;
  state_e state_q, state_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] blink_q, blink_d;
  logic oe_q, oe_d, ntrst_q, ntrst_d, status_q, status_d;
  logic busy_q, busy_d, led_q, led_d;

  assign srst_req_s = srst_req_q[SYNC_STAGES-1];
  assign trst_req_s = trst_req_q[SYNC_STAGES-1];
  assign nsrst_s    = nsrst_in_q[SYNC_STAGES-1];

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk_i    (CLK),
    .rst_i    (RST),
    .button_i (BUTTON),
    .press_o  (press)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      srst_req_q <= '0;
      trst_req_q <= '0;
      nsrst_in_q <= '1;
    end else begin
      srst_req_q <= {srst_req_q[SYNC_STAGES-2:0], HOST_SRST_REQ};
      trst_req_q <= {trst_req_q[SYNC_STAGES-2:0], HOST_TRST_REQ};
      nsrst_in_q <= {nsrst_in_q[SYNC_STAGES-2:0], NSRST_IN};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      blink_q  <= '0;
      oe_q     <= 1'b0;
      ntrst_q  <= 1'b1;
      status_q <= 1'b0;
      busy_q   <= 1'b0;
      led_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      blink_q  <= blink_d;
      oe_q     <= oe_d;
      ntrst_q  <= ntrst_d;
      status_q <= status_d;
      busy_q   <= busy_d;
      led_q    <= led_d;
    end
  end

  // A new request always wins; the pin low seen in RELEASE is our own drive decaying.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (srst_req_s || press) state_d = ST_ASSERT;
        else if (!nsrst_s)       state_d = ST_EXT;
      end
      ST_ASSERT: begin
        if (press)                     cnt_d = '0;
        else if (cnt_q != PULSE_LAST)  cnt_d = cnt_q + 1'b1;
        else if (!srst_req_s)          state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (srst_req_s || press)    state_d = ST_ASSERT;
        else if (nsrst_s)           state_d = ST_IDLE;
        else if (cnt_q == REL_LAST) state_d = ST_EXT;
        else                        cnt_d = cnt_q + 1'b1;
      end
      ST_EXT: begin
        if (srst_req_s || press) state_d = ST_ASSERT;
        else if (nsrst_s)        state_d = ST_IDLE;
      end
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_comb begin
    oe_d     = (state_d == ST_ASSERT);
    busy_d   = (state_d != ST_IDLE);
    status_d = (state_d == ST_EXT);
    ntrst_d  = ~(trst_req_s | (TRST_EN & (state_d == ST_ASSERT)));
    blink_d  = '0;
    led_d    = 1'b1;
    if (state_d == ST_IDLE) begin
      led_d = 1'b0;
    end else if (state_d == ST_EXT && state_q == ST_EXT) begin
      if (blink_q == BLINK_LAST) begin
        led_d = ~led_q;
      end else begin
        blink_d = blink_q + 1'b1;
        led_d   = led_q;
      end
    end
  end

  assign NSRST_OE    = oe_q;
  assign NTRST       = ntrst_q;
  assign SRST_STATUS = status_q;
  assign BUSY        = busy_q;
  assign LED         = led_q;

endmodule

// File: tb/tb_srst_sequencer.sv
// Bench for srst_sequencer: directed timing checks plus randomized traffic
// compared every cycle against a timestamp-based behavioural model.
module tb_srst_sequencer;

  localparam int DEB = 4, MINP = 8, RT = 16, BLK = 4, TWS = 1;

  logic CLK = 1'b0, RST = 1'b1;
  logic BUTTON = 1'b1, HOST_SRST_REQ = 1'b0, HOST_TRST_REQ = 1'b0, tgt_low = 1'b0;
  logic NSRST_IN, NSRST_OE, NTRST, SRST_STATUS, BUSY, LED;
  int   errors = 0, checks = 0;
  bit   cmp_en = 1'b0;

  // Open-drain pin: low if we pull it or the target does.
  assign NSRST_IN = ~(NSRST_OE | tgt_low);

  always #5 CLK = ~CLK;

  srst_sequencer #(
    .DEBOUNCE_CYCLES(DEB), .MIN_PULSE_CYCLES(MINP), .RELEASE_TIMEOUT(RT),
    .BLINK_DIV(BLK), .TRST_WITH_SRST(TWS)
  ) dut (
    .CLK(CLK), .RST(RST), .BUTTON(BUTTON), .HOST_SRST_REQ(HOST_SRST_REQ),
    .HOST_TRST_REQ(HOST_TRST_REQ), .NSRST_IN(NSRST_IN), .NSRST_OE(NSRST_OE),
    .NTRST(NTRST), .SRST_STATUS(SRST_STATUS), .BUSY(BUSY), .LED(LED)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_PULSE, M_WAITPIN, M_TARGET} mode_t;
  mode_t m = M_IDLE;
  int   cyc, until_c, rel_c, ext_c, run;
  logic [1:0] hreq, htr, hbtn, hpin;   // [0] = sampled last edge, [1] = two edges ago
  logic stable, press, req, trs, pin, sb, pr, pin_now;
  logic m_oe = 1'b0, m_ntrst = 1'b1, m_st = 1'b0, m_busy = 1'b0, m_led = 1'b0;

  initial forever begin
    @(posedge CLK or posedge RST);
    if (RST) begin
      m = M_IDLE; cyc = 0; run = 0; hreq = '0; htr = '0; hbtn = '1; hpin = '1;
      stable = 1'b1; press = 1'b0;
      m_oe = 1'b0; m_ntrst = 1'b1; m_st = 1'b0; m_busy = 1'b0; m_led = 1'b0;
    end else begin
      cyc++;
      pin_now = ~(m_oe | tgt_low);
      req = hreq[1]; trs = htr[1]; pin = hpin[1]; sb = hbtn[1]; pr = press;
      press = 1'b0;
      if (sb != stable) begin
        run++;
        if (run == DEB) begin stable = sb; run = 0; press = ~sb; end
      end else run = 0;
      case (m)
        M_IDLE:    if (req || pr) begin m = M_PULSE; until_c = cyc + MINP; end
                   else if (!pin) begin m = M_TARGET; ext_c = cyc; end
        M_PULSE:   if (pr) until_c = cyc + MINP;
                   else if (cyc >= until_c && !req) begin m = M_WAITPIN; rel_c = cyc; end
        M_WAITPIN: if (req || pr) begin m = M_PULSE; until_c = cyc + MINP; end
                   else if (pin) m = M_IDLE;
                   else if (cyc - rel_c == RT) begin m = M_TARGET; ext_c = cyc; end
        M_TARGET:  if (req || pr) begin m = M_PULSE; until_c = cyc + MINP; end
                   else if (pin) m = M_IDLE;
      endcase
      m_oe    = (m == M_PULSE);
      m_busy  = (m != M_IDLE);
      m_st    = (m == M_TARGET);
      m_ntrst = ~(trs | ((TWS != 0) && m == M_PULSE));
      m_led   = (m == M_IDLE) ? 1'b0 :
                (m == M_TARGET) ? ((((cyc - ext_c) / BLK) % 2) == 0) : 1'b1;
      hreq = {hreq[0], HOST_SRST_REQ};
      htr  = {htr[0], HOST_TRST_REQ};
      hbtn = {hbtn[0], BUTTON};
      hpin = {hpin[0], pin_now};
    end
  end

  always @(negedge CLK) if (cmp_en) begin
    check("model_nsrst_oe", NSRST_OE, m_oe);
    check("model_ntrst", NTRST, m_ntrst);
    check("model_srst_status", SRST_STATUS, m_st);
    check("model_busy", BUSY, m_busy);
    check("model_led", LED, m_led);
  end

  // ---------------- directed helpers ----------------
  function automatic logic sig(input int sel);
    case (sel)
      0:       return NSRST_OE;
      1:       return BUSY;
      2:       return SRST_STATUS;
      default: return NTRST;
    endcase
  endfunction

  // Edges until sig(sel)==val, sampled 1 unit after each rising edge; -1 on timeout.
  task automatic wait_for(input int sel, input logic val, input int limit, output int n);
    bit hit = 1'b0;
    n = 0;
    while (!hit && n < limit) begin
      @(posedge CLK); #1; n++;
      if (sig(sel) == val) hit = 1'b1;
    end
    if (!hit) n = -1;
  endtask

  // Called when NSRST_OE was just seen high; w = high cycles, tl = NTRST-low cycles among them.
  task automatic high_width(input int limit, output int w, output int tl);
    bit done = 1'b0;
    w = 1; tl = NTRST ? 0 : 1;
    while (!done && w < limit) begin
      @(posedge CLK); #1;
      if (!NSRST_OE) done = 1'b1;
      else begin w++; if (!NTRST) tl++; end
    end
  endtask

  task automatic pulse_req(input int len);
    HOST_SRST_REQ = 1'b1;
    fork
      begin repeat (len) @(negedge CLK); HOST_SRST_REQ = 1'b0; end
    join_none
  endtask

  int n, w, tl, bounce_left;
  bit seen;
  logic [11:0] pat;

  initial begin
    repeat (3) @(negedge CLK);
    check("rst_nsrst_oe", NSRST_OE, 0);
    check("rst_ntrst", NTRST, 1);
    check("rst_srst_status", SRST_STATUS, 0);
    check("rst_busy", BUSY, 0);
    check("rst_led", LED, 0);
    RST = 1'b0; cmp_en = 1'b1;
    repeat (2) @(negedge CLK);

    // Short host pulse
    HOST_SRST_REQ = 1'b1;
    @(posedge CLK); #1; check("short_oe_edge0", NSRST_OE, 0);
    @(posedge CLK); #1; check("short_oe_edge1", NSRST_OE, 0);
    @(negedge CLK); HOST_SRST_REQ = 1'b0;
    @(posedge CLK); #1; check("short_oe_edge2", NSRST_OE, 1);
    check("short_ntrst_edge2", NTRST, 0);
    high_width(40, w, tl);
    check("short_width", w, 8);
    check("short_ntrst_low", tl, 8);
    check("short_ntrst_after", NTRST, 1);
    wait_for(1, 1'b0, 20, n); check("short_idle_latency", n, 3);

    // Long host hold
    @(negedge CLK); pulse_req(20);
    wait_for(0, 1'b1, 10, n); check("long_rise", n, 3);
    high_width(60, w, tl); check("long_width", w, 20);
    check("long_busy_release", BUSY, 1);
    wait_for(1, 1'b0, 20, n); check("long_idle_latency", n, 3);

    // Bounce, then a clean 6-cycle press
    @(negedge CLK); seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      BUTTON = ~BUTTON;
      repeat (2) begin @(posedge CLK); #1; if (NSRST_OE || BUSY) seen = 1'b1; end
      @(negedge CLK);
    end
    repeat (8) begin @(posedge CLK); #1; if (NSRST_OE || BUSY) seen = 1'b1; end
    check("bounce_no_press", seen, 0);
    @(negedge CLK); BUTTON = 1'b0;
    fork begin repeat (6) @(negedge CLK); BUTTON = 1'b1; end join_none
    wait_for(0, 1'b1, 30, n); check("button_rise", n, 7);
    high_width(40, w, tl); check("button_width", w, 8);
    wait_for(1, 1'b0, 20, n); check("button_idle", n, 3);

    // External (target) reset with LED blink
    @(negedge CLK); tgt_low = 1'b1;
    wait_for(2, 1'b1, 10, n); check("ext_detect", n, 3);
    pat[11] = LED;
    for (int i = 10; i >= 0; i--) begin @(posedge CLK); #1; pat[i] = LED; end
    check("ext_led_pattern", pat, 12'b1111_0000_1111);
    repeat (17) @(negedge CLK); tgt_low = 1'b0;
    wait_for(2, 1'b0, 10, n); check("ext_release", n, 3);
    check("ext_led_idle", LED, 0);

    // Release timeout: target keeps the pin low after our pulse
    @(negedge CLK); tgt_low = 1'b1; pulse_req(1);
    wait_for(0, 1'b1, 10, n); check("tmo_rise", n, 3);
    high_width(40, w, tl); check("tmo_width", w, 8);
    wait_for(2, 1'b1, 40, n); check("tmo_ext_entry", n, 16);
    @(negedge CLK); tgt_low = 1'b0;
    wait_for(1, 1'b0, 10, n); check("tmo_idle", n, 3);

    // Asynchronous reset in the middle of a pulse
    @(negedge CLK); pulse_req(1);
    wait_for(0, 1'b1, 10, n); check("arst_rise", n, 3);
    repeat (4) @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    check("arst_nsrst_oe", NSRST_OE, 0);
    check("arst_ntrst", NTRST, 1);
    check("arst_led", LED, 0);
    check("arst_busy", BUSY, 0);
    @(negedge CLK); RST = 1'b0;
    @(negedge CLK); pulse_req(1);
    wait_for(0, 1'b1, 10, n); check("arst_next_rise", n, 3);
    high_width(40, w, tl); check("arst_next_width", w, 8);
    wait_for(1, 1'b0, 20, n); check("arst_next_idle", n, 3);

    // Randomized traffic, checked only by the model
    bounce_left = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge CLK);
      if ($urandom_range(0, 19) == 0) HOST_SRST_REQ = ~HOST_SRST_REQ;
      if ($urandom_range(0, 9) == 0)  HOST_TRST_REQ = ~HOST_TRST_REQ;
      if ($urandom_range(0, 29) == 0) tgt_low = ~tgt_low;
      if (bounce_left > 0) begin
        BUTTON = 1'($urandom_range(0, 1));
        bounce_left--;
      end else if ($urandom_range(0, 39) == 0) begin
        BUTTON = ~BUTTON;
        bounce_left = $urandom_range(0, 5);
      end
      if ($urandom_range(0, 299) == 0) begin
        #2 RST = 1'b1;
        @(negedge CLK); RST = 1'b0;
      end
    end

    @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
